// File: rtl/serial_write_queue_pkg.sv
// Shared types for the serial write queue: shifter FSM states and FIFO pointer sizing.
package serial_write_queue_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // One extra pointer bit distinguishes full from empty when the index bits match.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 32'd1;
   endfunction

endpackage

// File: rtl/serial_write_queue_sync_fifo.sv
// Small synchronous FIFO feeding the serial shifter; full/empty decode straight from the pointer registers.
module sync_fifo
   import serial_write_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             overflow_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned IDX_W = PTR_W - 32'd1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign data_o     = mem_q[rd_ptr_q[IDX_W-1:0]];
   assign overflow_o = overflow_q;

   // Pointer advance; a flush wins over push and pop, and a push while full is dropped.
   always_comb begin
      do_push_s  = 1'b0;
      do_pop_s   = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = 1'b0;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         do_push_s  = push_i && !full_o;
         do_pop_s   = pop_i && !empty_o;
         overflow_d = push_i && full_o;
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer and overflow-pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Word storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/serial_write_queue.sv
// Queued serial writer: words from the protocol core wait in a FIFO and leave one bit per
// write_sig strobe, back to back, with the line parked at IDLE_LEVEL whenever nothing is loaded.
module serial_write_queue
   import serial_write_queue_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          LSB_FIRST  = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WORD_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   input  logic                  write_sig,
   input  logic                  abort,
   output logic                  data_out,
   output logic                  busy,
   output logic                  done_sig,
   output logic                  overflow,
   output logic                  underrun
);

   localparam int unsigned       CNT_W    = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_WIDTH - 32'd1);

   state_e                state_q, state_d;
   logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  data_out_q, data_out_d;
   logic                  done_q, done_d;
   logic                  underrun_q, underrun_d;
   logic                  pop_s;
   logic [WORD_WIDTH-1:0] fifo_data_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  fifo_ovf_s;

   sync_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (sys_clk),
      .rst_ni     (rst),
      .flush_i    (abort),
      .push_i     (wr_en),
      .data_i     (wr_data),
      .pop_i      (pop_s),
      .data_o     (fifo_data_s),
      .full_o     (fifo_full_s),
      .empty_o    (fifo_empty_s),
      .overflow_o (fifo_ovf_s)
   );

   assign full     = fifo_full_s;
   assign empty    = fifo_empty_s;
   assign overflow = fifo_ovf_s;
   assign busy     = (state_q == ST_SHIFT);
   assign data_out = data_out_q;
   assign done_sig = done_q;
   assign underrun = underrun_q;

   // Shifter FSM: load from the FIFO whenever a word is waiting and the shifter is free or finishing.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      pop_s      = 1'b0;
      data_out_d = IDLE_LEVEL;
      if (abort) begin
         state_d   = ST_IDLE;
         shreg_d   = '0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               underrun_d = write_sig;
               if (!fifo_empty_s) begin
                  pop_s     = 1'b1;
                  shreg_d   = fifo_data_s;
                  bit_cnt_d = '0;
                  state_d   = ST_SHIFT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (write_sig) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     done_d = 1'b1;
                     if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        shreg_d   = fifo_data_s;
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
                     if (LSB_FIRST) begin
                        shreg_d = {1'b0, shreg_q[WORD_WIDTH-1:1]};
                     end else begin
                        shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
                     end
                  end
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      // The line shows the head bit of whatever the shifter will hold after this edge.
      if (state_d == ST_SHIFT) begin
         data_out_d = LSB_FIRST ? shreg_d[0] : shreg_d[WORD_WIDTH-1];
      end else begin
         data_out_d = IDLE_LEVEL;
      end
   end

   // Shifter, FSM and output registers.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         data_out_q <= IDLE_LEVEL;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

endmodule

// File: tb/tb_serial_write_queue.sv
// Bench for serial_write_queue: an MSB-first and an LSB-first instance share stimulus and are
// checked every cycle against a queue-based model, plus literal bit-sequence expectations.
module tb_serial_write_queue;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       write_sig = 1'b0;
   logic       abort = 1'b0;

   logic full_m, empty_m, data_out_m, busy_m, done_m, ovf_m, und_m;
   logic full_l, empty_l, data_out_l, busy_l, done_l, ovf_l, und_l;

   int tests = 0;
   int failed = 0;

   // model state
   logic [7:0] mq[$];
   logic [7:0] m_cur;
   int         m_idx;
   bit         m_act;
   bit         e_done, e_ovf, e_und;

   logic cap_m[$];
   logic cap_l[$];
   int   done_cnt_m;

   always #5 sys_clk = ~sys_clk;

   serial_write_queue #(.WORD_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_m (
      .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_m), .empty(empty_m),
      .write_sig(write_sig), .abort(abort), .data_out(data_out_m), .busy(busy_m), .done_sig(done_m),
      .overflow(ovf_m), .underrun(und_m));

   serial_write_queue #(.WORD_WIDTH(8), .FIFO_DEPTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_l (
      .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full_l), .empty(empty_l),
      .write_sig(write_sig), .abort(abort), .data_out(data_out_l), .busy(busy_l), .done_sig(done_l),
      .overflow(ovf_l), .underrun(und_l));

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_act  = 1'b0;
      m_idx  = 0;
      e_done = 1'b0;
      e_ovf  = 1'b0;
      e_und  = 1'b0;
   endtask

   task automatic model_step(input bit we, input logic [7:0] wd, input bit ws, input bit ab);
      int sz;
      bit load;
      e_done = 1'b0;
      e_ovf  = 1'b0;
      e_und  = 1'b0;
      load   = 1'b0;
      if (ab) begin
         mq.delete();
         m_act = 1'b0;
      end else begin
         sz = mq.size();
         if (!m_act) begin
            e_und = ws;
            load  = (sz != 0);
         end else if (ws) begin
            if (m_idx == 7) begin
               e_done = 1'b1;
               if (sz != 0) load = 1'b1;
               else m_act = 1'b0;
            end else begin
               m_idx++;
            end
         end
         if (load) begin
            m_cur = mq.pop_front();
            m_idx = 0;
            m_act = 1'b1;
         end
         if (we) begin
            if (sz == 4) e_ovf = 1'b1;
            else mq.push_back(wd);
         end
      end
   endtask

   function automatic logic exp_bit(input bit lsb);
      if (!m_act) return 1'b1;
      if (lsb) return m_cur[m_idx];
      return m_cur[7 - m_idx];
   endfunction

   task automatic chk_dut(input string tag, input logic f, input logic e, input logic b, input logic d,
                          input logic dn, input logic o, input logic u, input bit lsb);
      chk1({tag, "_full"}, f, mq.size() == 4);
      chk1({tag, "_empty"}, e, mq.size() == 0);
      chk1({tag, "_busy"}, b, m_act);
      chk1({tag, "_data_out"}, d, exp_bit(lsb));
      chk1({tag, "_done"}, dn, e_done);
      chk1({tag, "_overflow"}, o, e_ovf);
      chk1({tag, "_underrun"}, u, e_und);
   endtask

   // One clock: drive, advance model at the edge, compare both instances just after it.
   task automatic step(input bit we, input logic [7:0] wd, input bit ws, input bit ab);
      wr_en = we;
      wr_data = wd;
      write_sig = ws;
      abort = ab;
      if (ws) begin
         cap_m.push_back(data_out_m);
         cap_l.push_back(data_out_l);
      end
      @(posedge sys_clk);
      model_step(we, wd, ws, ab);
      #1;
      wr_en = 1'b0;
      write_sig = 1'b0;
      abort = 1'b0;
      chk_dut("msb", full_m, empty_m, busy_m, data_out_m, done_m, ovf_m, und_m, 1'b0);
      chk_dut("lsb", full_l, empty_l, busy_l, data_out_l, done_l, ovf_l, und_l, 1'b1);
      if (done_m === 1'b1) done_cnt_m++;
   endtask

   function automatic logic [63:0] pack_bits(input bit lsb);
      logic [63:0] v;
      v = 64'd0;
      if (lsb) begin
         foreach (cap_l[i]) v = {v[62:0], cap_l[i]};
      end else begin
         foreach (cap_m[i]) v = {v[62:0], cap_m[i]};
      end
      return v;
   endfunction

   task automatic clear_caps();
      cap_m.delete();
      cap_l.delete();
      done_cnt_m = 0;
   endtask

   task automatic check_reset_literals(input string tag);
      chk1({tag, "_rst_data_out_m"}, data_out_m, 1'b1);
      chk1({tag, "_rst_data_out_l"}, data_out_l, 1'b1);
      chk1({tag, "_rst_busy"}, busy_m | busy_l, 1'b0);
      chk1({tag, "_rst_full"}, full_m | full_l, 1'b0);
      chk1({tag, "_rst_empty"}, empty_m & empty_l, 1'b1);
      chk1({tag, "_rst_pulses"}, done_m | ovf_m | und_m | done_l | ovf_l | und_l, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fill [5];
      fill[0] = 8'h21; fill[1] = 8'h32; fill[2] = 8'h43; fill[3] = 8'h54; fill[4] = 8'h65;
      model_reset();
      clear_caps();
      #2 rst = 1'b0;
      #10;
      check_reset_literals("init");
      rst = 1'b1;
      @(posedge sys_clk);
      #1;

      // 6: underrun while idle and empty
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk1("t6_underrun", und_m, 1'b1);
      chk1("t6_line_idle", data_out_m, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk1("t6_underrun_clears", und_m, 1'b0);

      // 1 and 2: single word 8'h9c
      clear_caps();
      step(1'b1, 8'h9c, 1'b0, 1'b0);
      chk1("t1_empty_after_push", empty_m, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk1("t1_busy_after_load", busy_m, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chkv("t1_msb_bits", pack_bits(1'b0), 64'h9c);
      chkv("t2_lsb_bits", pack_bits(1'b1), 64'h39);
      chkv("t1_bit_count", 64'(cap_m.size()), 64'd8);
      chkv("t1_done_count", 64'(done_cnt_m), 64'd1);
      chk1("t1_idle_line", data_out_m, 1'b1);

      // 3: back-to-back words, simultaneous push and pop on the second push
      clear_caps();
      step(1'b1, 8'he4, 1'b0, 1'b0);
      step(1'b1, 8'hb5, 1'b0, 1'b0);
      chk1("t3_push_pop_count", empty_m, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk1("t3_done_position", done_m, (i == 8) || (i == 16));
         if (i < 16) chk1("t3_busy_held", busy_m, 1'b1);
      end
      chkv("t3_msb_bits", pack_bits(1'b0), 64'he4b5);
      chkv("t3_lsb_bits", pack_bits(1'b1), 64'h27ad);
      chk1("t3_idle_after", busy_m, 1'b0);

      // 4: fill while the shifter holds a word, then overflow (also during a pop)
      clear_caps();
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, fill[i], 1'b0, 1'b0);
         if (i == 3) chk1("t4_full_after_4th", full_m, 1'b1);
      end
      chk1("t4_overflow_5th", ovf_m, 1'b1);
      for (int i = 1; i <= 8; i++) step(i == 8, 8'h77, 1'b1, 1'b0);
      chk1("t4_overflow_with_pop", ovf_m, 1'b1);
      chk1("t4_not_full_after_pop", full_m, 1'b0);
      for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chkv("t4_msb_bits", pack_bits(1'b0), 64'h1121324354);
      chkv("t4_done_count", 64'(done_cnt_m), 64'd5);
      chk1("t4_drained", empty_m & ~busy_m, 1'b1);

      // 5a: abort mid-word with a same-cycle write that must be discarded
      clear_caps();
      step(1'b1, 8'he4, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'hff, 1'b0, 1'b1);
      chk1("t5_abort_busy", busy_m, 1'b0);
      chk1("t5_abort_line", data_out_m, 1'b1);
      chk1("t5_abort_wr_dropped", empty_m, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chkv("t5_abort_no_done", 64'(done_cnt_m), 64'd0);

      // 5b: asynchronous reset mid-word, then a clean word
      step(1'b1, 8'he4, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      rst = 1'b0;
      #1;
      check_reset_literals("mid");
      model_reset();
      #2 rst = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      clear_caps();
      step(1'b1, 8'hb5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chkv("t5_after_msb_bits", pack_bits(1'b0), 64'hb5);
      chkv("t5_after_lsb_bits", pack_bits(1'b1), 64'had);
      chkv("t5_after_done_count", 64'(done_cnt_m), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
